regfile_ab: RTL

REGFILE_AB -- requirements
Module: regfile_ab

---
 rtl/regfile_ab.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_ab.sv
// Parameterised register file with two registered read operands (A/B),
// write-through bypass, and a sequential clear engine that wipes one register per cycle.
module regfile_ab #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    input  logic              loada,
    input  logic              loadb,
    input  logic              clear_req,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done
);

    localparam int unsigned N = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   regs_q [N];
    logic [DATA_W-1:0]   regs_d [N];

    logic                wr_en;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;

    // Writes (and therefore the bypass path) only exist while idle.
    assign wr_en = (state_q == IDLE) && write;

    always_comb begin
        op_a = regs_q[readnum_a];
        op_b = regs_q[readnum_b];
        if (wr_en && (writenum == readnum_a)) begin
            op_a = data_in;
        end
        if (wr_en && (writenum == readnum_b)) begin
            op_b = data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        regs_d  = regs_q;
        a_d     = loada ? op_a : a_q;
        b_d     = loadb ? op_b : b_q;

        case (state_q)
            IDLE: begin
                if (write) begin
                    regs_d[writenum] = data_in;
                end
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                // Last index: counter wraps to 0 as we return to IDLE.
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            regs_q  <= regs_d;
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign busy = (state_q == CLEAR);
    assign done = done_q;

endmodule
